imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time writer for the instruction memory. Receives a byte stream from a
//   host link (UART RX or debug port) over a valid/ready handshake, packs the
//   bytes into 32-bit little-endian words, and issues one write per word.
//   Holds the pipeline in reset while loading and releases it when the image is
//   complete. Sits between the host byte source and the instruction memory's
//   write port.
// PARAMETERS
//   DEPTH      1024      instruction memory size in words; max legal word count
//   TIMEOUT    65535     max idle cycles between bytes inside a frame (>=2)
//   BASE_ADDR  32'h0     byte address of the first written word (word aligned)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-low (0 = reset)
//   start        in   1   1-cycle pulse; begins a load from IDLE/DONE/ERR
//   in_valid     in   1   host byte valid
//   in_data      in   8   host byte
//   in_ready     out  1   loader accepts in_data this cycle
//   mem_we       out  1   instruction memory write enable, 1-cycle pulse
//   mem_addr     out  32  write byte address (bits [1:0] always 0)
//   mem_wdata    out  32  write data
//   core_rst     out  1   active-low reset to pipeline; 0 while loading or in ERR
//   busy         out  1   load in progress (HDR0..WRITE)
//   done         out  1   level; image loaded successfully
//   error        out  1   level; load aborted
//   words_loaded out  16  words written since last start
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; in_ready=0, mem_we=0, mem_addr=0,
//     mem_wdata=0, core_rst=1, busy=0, done=0, error=0, words_loaded=0,
//     byte/timeout counters cleared. A write in flight is dropped.
//   All outputs registered. A byte is accepted on a rising edge with in_valid&&in_ready.
//   Frame: 2 header bytes = word count N (little-endian 16 bit), then 4*N data
//     bytes; byte k of a word goes to bits [8k+7:8k].
//   States:
//     IDLE : core_rst=1. start -> HDR0 (next cycle), words_loaded<=0.
//     HDR0 : in_ready=1, core_rst=0, no timeout. Byte -> HDR1.
//     HDR1 : in_ready=1. Byte -> N formed; N==0 -> DONE; N>DEPTH -> ERR;
//            else DATA with lane=0, idx=0.
//     DATA : in_ready=1. 4th byte accepted -> WRITE.
//     WRITE: in_ready=0 (one cycle, backpressure); mem_we=1,
//            mem_addr=BASE_ADDR+4*idx, mem_wdata=packed word; words_loaded+1.
//            idx+1==N -> DONE, else DATA.
//     DONE : done=1, core_rst=1. start -> HDR0 (clears done).
//     ERR  : error=1, core_rst=0 (core held). start -> HDR0 (clears error).
//   Timeout: in HDR1/DATA a counter counts consecutive cycles with no accepted
//     byte; reaching TIMEOUT -> ERR. Counter clears on every accepted byte.
//   start is ignored while busy=1. start and a byte in the same IDLE cycle:
//     the byte is not accepted (in_ready=0 in IDLE).
//   Latency: mem_we asserts the cycle after the 4th byte of a word is accepted;
//     minimum load time = 1 + 2 + 5*N cycles from start to done.
//   idx/words_loaded never wrap: N<=DEPTH<=65535 is guaranteed by the ERR check.
// TESTING
//   1. start; bytes 02 00 03 A3 C4 FF 83 23 83 00 -> mem_we@0x0=FFC4A303,
//      @0x4=00832383; done=1, core_rst=1, words_loaded=2.
//   2. start; header 00 00 -> done=1 one cycle after 2nd byte, no mem_we pulse.
//   3. DEPTH=1024; header 01 04 (N=1025) -> error=1, core_rst=0, no mem_we.
//   4. TIMEOUT=16: gap of 15 idle cycles after a data byte -> load completes;
//      gap of 16 -> error=1, no further writes; start then re-loads cleanly.
//   5. in_valid held 1 continuously -> in_ready drops exactly in WRITE cycles,
//      no byte lost or duplicated (compare 8-word image).
//   6. rst=0 mid-DATA -> outputs reset values immediately; start pulsed while
//      busy -> ignored; start from DONE -> new load, done cleared.

Source files
------------

// File: rtl/imem_loader_if.sv
// Bus bundle between the boot loader, the host byte source and the instruction
// memory write port.
//   in_valid  : host byte valid
//   in_data   : host byte
//   in_ready  : loader accepts in_data this cycle
//   mem_we    : instruction memory write enable (1-cycle pulse)
//   mem_addr  : write byte address, word aligned
//   mem_wdata : write data
// Modports:
//   master : the loader. Sinks the byte stream and drives the memory write port.
//   slave  : the environment. Host byte source plus instruction memory.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer.
// Accepts a framed byte stream (2-byte little-endian word count N followed by
// 4*N data bytes), packs each group of four bytes into a little-endian 32-bit
// word and writes it to consecutive word addresses starting at BASE_ADDR. The
// pipeline is held in reset while a load is in progress or after an aborted
// load, and released once the image is complete.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   start        : 1-cycle pulse, begins a load from idle/done/error
//   bus          : byte stream in, memory write port out (imem_loader_if.master)
//   core_rst     : active-low reset to the pipeline
//   busy         : load in progress
//   done         : image loaded successfully (level)
//   error        : load aborted (level)
//   words_loaded : words written since the last start
// All outputs are registered.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned TIMEOUT   = 65535,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    hdr_lo_q, hdr_lo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_q, word_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_ready_q;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]   words_q, words_d;
  logic          core_rst_q, busy_q, done_q, error_q;

  logic          accept;
  logic [15:0]   n_hdr;
  logic          last_word;
  logic          timeout_hit;

  assign accept      = bus.in_valid && in_ready_q;
  assign n_hdr       = {bus.in_data, hdr_lo_q};
  assign last_word   = ((idx_q + 16'd1) == n_q);
  // This idle cycle would bring the idle count up to TIMEOUT.
  assign timeout_hit = !accept && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    hdr_lo_d    = hdr_lo_q;
    n_d         = n_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    word_d      = word_q;
    tmo_d       = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr0;
          words_d = '0;
        end
      end

      StHdr0: begin
        if (accept) begin
          hdr_lo_d = bus.in_data;
          state_d  = StHdr1;
        end
      end

      StHdr1: begin
        if (accept) begin
          n_d    = n_hdr;
          idx_d  = '0;
          lane_d = '0;
          if (n_hdr == 16'd0) begin
            state_d = StDone;
          end else if (32'(n_hdr) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end else if (timeout_hit) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StData: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            state_d     = StWrite;
            lane_d      = '0;
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + {14'b0, idx_q, 2'b00};
            mem_wdata_d = {bus.in_data, word_q};
            words_d     = words_q + 16'd1;
          end else begin
            // Shift in from the top: after three bytes byte 0 sits in [7:0].
            word_d = {bus.in_data, word_q[23:8]};
            lane_d = lane_q + 2'd1;
          end
        end else if (timeout_hit) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StWrite: begin
        // Single backpressure cycle; the idle counter restarts when DATA resumes.
        idx_d   = idx_q + 16'd1;
        state_d = last_word ? StDone : StData;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hdr_lo_q    <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_lo_q    <= hdr_lo_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
      // Status outputs decoded from the next state so they align with it.
      in_ready_q  <= (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData);
      busy_q      <= (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData) ||
                     (state_d == StWrite);
      core_rst_q  <= (state_d == StIdle) || (state_d == StDone);
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StErr);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst      = core_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH    (1024),
    .TIMEOUT  (16),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write pulse is popped against the expected {addr, data}.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%08h data=%08h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== mon_e)
          $display("FAIL write_data: got addr=%08h data=%08h, required addr=%08h data=%08h",
                   bus.mem_addr, bus.mem_wdata, mon_e[63:32], mon_e[31:0]);
        else n_pass++;
      end
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; bounded wait for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL send_byte: byte %02h got in_ready=0 for 40 cycles, required 1", b);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.mem_we, core_rst, busy, done, error} !== 6'b001000)
      $display("FAIL reset_flags: got rdy,we,crst,busy,done,err=%b required 001000",
               {bus.in_ready, bus.mem_we, core_rst, busy, done, error});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, words_loaded} !== 80'h0)
      $display("FAIL reset_regs: got addr=%h data=%h words=%0d required all 0",
               bus.mem_addr, bus.mem_wdata, words_loaded);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h83, 8'h23, 8'h83, 8'h00};
    pulse_start;
    n_checks++;
    if ({busy, core_rst, done, bus.in_ready} !== 4'b1001)
      $display("FAIL basic_start: got busy,crst,done,rdy=%b required 1001",
               {busy, core_rst, done, bus.in_ready});
    else n_pass++;
    exp_q.push_back({32'h0, 32'hFFC4A303});
    exp_q.push_back({32'h4, 32'h00832383});
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, core_rst, busy, error} !== 4'b1100 || words_loaded !== 16'd2)
      $display("FAIL basic_done: got done,crst,busy,err=%b words=%0d required 1100 words=2",
               {done, core_rst, busy, error}, words_loaded);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL basic_writes: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_zero;
    pulse_start;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n_checks++;
    if ({done, core_rst, busy} !== 3'b110 || words_loaded !== 16'd0)
      $display("FAIL zero_done: got done,crst,busy=%b words=%0d required 110 words=0",
               {done, core_rst, busy}, words_loaded);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    pulse_start;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    n_checks++;
    if ({error, core_rst, busy, done} !== 4'b1000)
      $display("FAIL overflow_err: got err,crst,busy,done=%b required 1000",
               {error, core_rst, busy, done});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout;
    // Gap of 15 idle cycles must not abort.
    pulse_start;
    n_checks++;
    if ({error, busy} !== 2'b01)
      $display("FAIL timeout_restart: got err,busy=%b required 01", {error, busy});
    else n_pass++;
    exp_q.push_back({32'h0, 32'h44332211});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 15);
    send_byte(8'h44, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, error} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL timeout_gap15: got done,err=%b pending=%0d required 10 pending=0",
               {done, error}, exp_q.size());
    else n_pass++;
    // Gap of 16 idle cycles aborts.
    pulse_start;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if ({error, busy} !== 2'b01)
      $display("FAIL timeout_15idle: got err,busy=%b required 01", {error, busy});
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({error, busy, core_rst} !== 3'b100)
      $display("FAIL timeout_16idle: got err,busy,crst=%b required 100", {error, busy, core_rst});
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    // Clean reload from the error state.
    pulse_start;
    n_checks++;
    if ({error, busy} !== 2'b01)
      $display("FAIL timeout_clear: got err,busy=%b required 01", {error, busy});
    else n_pass++;
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, error} !== 2'b10 || words_loaded !== 16'd1 || exp_q.size() != 0)
      $display("FAIL timeout_reload: got done,err=%b words=%0d pending=%0d required 10 1 0",
               {done, error}, words_loaded, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] img [34];
    int i;
    int stalls;
    int bad;
    int cyc;
    bit rdy;
    img[0] = 8'h08;
    img[1] = 8'h00;
    for (int k = 2; k < 34; k++) img[k] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 8; w++)
      exp_q.push_back({32'(4 * w), img[4*w+5], img[4*w+4], img[4*w+3], img[4*w+2]});
    pulse_start;
    i = 0;
    stalls = 0;
    bad = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data = img[0];
    while (i < 34 && cyc < 300) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (!rdy) stalls++;
      // While loading, in_ready must be low exactly when a write is issued.
      if (rdy === bus.mem_we) bad++;
      @(posedge clk);
      #1;
      if (rdy) begin
        i++;
        if (i < 34) bus.in_data = img[i];
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (i != 34 || stalls != 7 || bad != 0)
      $display("FAIL b2b_stream: got sent=%0d stalls=%0d bad=%0d required 34 7 0",
               i, stalls, bad);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 16'd8 || exp_q.size() != 0)
      $display("FAIL b2b_done: got done=%b words=%0d pending=%0d required 1 8 0",
               done, words_loaded, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    pulse_start;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.mem_we, core_rst, busy, done, error} !== 6'b001000 ||
        words_loaded !== 16'd0 || bus.mem_wdata !== 32'h0)
      $display("FAIL rstmid_outputs: got rdy,we,crst,busy,done,err=%b words=%0d required 001000 0",
               {bus.in_ready, bus.mem_we, core_rst, busy, done, error}, words_loaded);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // start while busy must not restart the frame.
    pulse_start;
    exp_q.push_back({32'h0, 32'h78563412});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_start;
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || words_loaded !== 16'd1 || exp_q.size() != 0)
      $display("FAIL busy_start: got done=%b words=%0d pending=%0d required 1 1 0",
               done, words_loaded, exp_q.size());
    else n_pass++;
    // start from DONE clears done and the word count.
    pulse_start;
    n_checks++;
    if ({done, busy, core_rst} !== 3'b010 || words_loaded !== 16'd0)
      $display("FAIL done_restart: got done,busy,crst=%b words=%0d required 010 0",
               {done, busy, core_rst}, words_loaded);
    else n_pass++;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n_checks++;
    if (done !== 1'b1) $display("FAIL done_reload: got done=%b required 1", done);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_overflow;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_pending: got %0d required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
